ternary_serial_alu: RTL and testbench

TERNARY_SERIAL_ALU -- requirements
Module: ternary_serial_alu

---
 rtl/ternary_pkg.sv | 23 ++
 rtl/ternary_trit_op.sv | 27 ++
 rtl/ternary_serial_alu.sv | 114 +++++++++++
 tb/tb_ternary_serial_alu.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary serial ALU: trit codes, op codes, FSM states.
// Pure declarations, no logic and no latency.
// No flow control of its own.
package ternary_pkg;

    // Two-bit trit encoding {hi,lo}; 11 never represents a value
    localparam logic [1:0] T0   = 2'b00;
    localparam logic [1:0] T1   = 2'b01;
    localparam logic [1:0] T2   = 2'b10;
    localparam logic [1:0] TILL = 2'b11;

    // Operation select
    localparam logic OP_MAX  = 1'b0;
    localparam logic OP_CONS = 1'b1;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ternary_trit_op.sv
// Single-trit max / consensus with illegal-code detection.
// Purely combinational, zero latency.
// No flow control; evaluated whenever its inputs change.
module ternary_trit_op
    import ternary_pkg::*;
(
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    input  logic       op_i,
    output logic [1:0] trit_o,
    output logic       illegal_o
);

    // Illegal operand forces 00; otherwise the encoding orders like the values
    always_comb begin
        illegal_o = (a_i == TILL) || (b_i == TILL);
        trit_o    = T0;
        if (!illegal_o) begin
            if (op_i == OP_CONS) begin
                trit_o = (a_i == b_i) ? a_i : T1;
            end else begin
                trit_o = (a_i > b_i) ? a_i : b_i;
            end
        end
    end

endmodule

// File: rtl/ternary_serial_alu.sv
// Serial ternary ALU: one trit of max/consensus per RUN cycle, index 0 first.
// Latency: start accepted at edge k, done visible in the cycle after edge k+TRITS.
// Backpressure: start is accepted only while ready (IDLE/DONE); ignored while busy.
module ternary_serial_alu
    import ternary_pkg::*;
#(
    parameter int TRITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 op,
    input  logic [2*TRITS-1:0]   a_word,
    input  logic [2*TRITS-1:0]   b_word,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*TRITS-1:0]   result,
    output logic                 err
);

    localparam int CW = (TRITS > 1) ? $clog2(TRITS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(TRITS - 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*TRITS-1:0] a_q, a_d;
    logic [2*TRITS-1:0] b_q, b_d;
    logic               op_q, op_d;
    logic [2*TRITS-1:0] result_q, result_d;
    logic               err_q, err_d;

    logic               accept;
    logic [CW:0]        bit_idx;
    logic [1:0]         trit_res;
    logic               trit_ill;

    assign accept  = start && ready;
    assign bit_idx = {cnt_q, 1'b0};

    // Operand trits selected by the counter feed the single shared trit unit
    ternary_trit_op u_trit_op (
        .a_i       (a_q[bit_idx +: 2]),
        .b_i       (b_q[bit_idx +: 2]),
        .op_i      (op_q),
        .trit_o    (trit_res),
        .illegal_o (trit_ill)
    );

    // State register plus datapath registers; reset wins over start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Next state: finish after the last trit index, chain directly from DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state alone
    always_comb begin
        ready = (state_q == IDLE) || (state_q == DONE);
        busy  = (state_q == RUN);
        done  = (state_q == DONE);
    end

    // Datapath: latch and clear on accept, write one trit per RUN cycle
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        if (accept) begin
            a_d      = a_word;
            b_d      = b_word;
            op_d     = op;
            cnt_d    = '0;
            result_d = '0;
            err_d    = 1'b0;
        end else if (state_q == RUN) begin
            result_d[bit_idx +: 2] = trit_res;
            err_d                  = err_q | trit_ill;
            cnt_d                  = cnt_q + 1'b1;
        end
    end

    assign result = result_q;
    assign err    = err_q;

endmodule

// File: tb/tb_ternary_serial_alu.sv
// Self-checking bench for ternary_serial_alu with TRITS=4.
// Directed sequence; expected results queued at launch, compared at done.
// Inputs driven 1 time unit after the rising edge, outputs sampled there too.
module tb_ternary_serial_alu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       op;
    logic [7:0] a_word;
    logic [7:0] b_word;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       err;

    typedef struct packed {
        logic [7:0] res;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ternary_serial_alu #(.TRITS(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a_word (a_word),
        .b_word (b_word),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: decode trits to integers and apply the operation
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic o);
        exp_t e;
        int   va, vb, vr;
        e.res = 8'h00;
        e.err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            va = int'(a[2*i +: 2]);
            vb = int'(b[2*i +: 2]);
            if (va == 3 || vb == 3) begin
                vr    = 0;
                e.err = 1'b1;
            end else if (o == 1'b0) begin
                vr = (va > vb) ? va : vb;
            end else begin
                vr = (va == vb) ? va : 1;
            end
            e.res[2*i +: 2] = vr[1:0];
        end
        return e;
    endfunction

    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic o);
        a_word = a;
        b_word = b;
        op     = o;
        start  = 1'b1;
        sb.push_back(model(a, b, o));
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        check({tag, "_done"}, done, 1);
        check({tag, "_sb_nonempty"}, sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_result"}, result, e.res);
            check({tag, "_err"}, err, e.err);
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic o);
        int cyc;
        launch(a, b, o);
        tick();
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_ready_low"}, ready, 0);
        wait_done(20, cyc);
        check({tag, "_latency"}, cyc + 1, 5);
        check_out(tag);
        tick();
        check({tag, "_single_done"}, done, 0);
        check({tag, "_idle_ready"}, ready, 1);
        check({tag, "_hold"}, result, model(a, b, o).res);
    endtask

    initial begin
        int cyc;
        int seen;

        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 1'b0;
        a_word = 8'h00;
        b_word = 8'h00;
        repeat (2) tick();
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 8'h00);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        // Max and consensus on mixed operands, consensus on equal operands
        run_op("max", 8'h92, 8'h19, 1'b0);
        run_op("cons", 8'h92, 8'h19, 1'b1);
        run_op("cons_eq", 8'h92, 8'h92, 1'b1);

        // Illegal trit: zero result, sticky err through IDLE, cleared by next start
        run_op("illegal", 8'h03, 8'h00, 1'b0);
        tick();
        check("err_sticky_idle", err, 1);
        launch(8'h92, 8'h92, 1'b1);
        tick();
        start = 1'b0;
        check("err_cleared_on_start", err, 0);
        check("result_cleared_on_start", result, 8'h00);
        wait_done(20, cyc);
        check_out("after_err");
        tick();

        // Start during RUN with different operands must be ignored
        launch(8'h92, 8'h19, 1'b0);
        tick();
        start = 1'b0;
        tick();
        a_word = 8'hFF;
        b_word = 8'hFF;
        op     = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check("ignore_busy", busy, 1);
        wait_done(20, cyc);
        check("ignore_latency", cyc + 3, 5);
        check_out("ignore");
        tick();
        check("ignore_single_done", done, 0);
        check("ignore_sb_empty", sb.size(), 0);

        // Start held high through DONE: back-to-back operations
        launch(8'h92, 8'h19, 1'b0);
        tick();
        wait_done(20, cyc);
        check_out("b2b_first");
        launch(8'h92, 8'h19, 1'b1);
        tick();
        start = 1'b0;
        check("b2b_no_idle", busy, 1);
        check("b2b_done_dropped", done, 0);
        wait_done(20, cyc);
        check("b2b_spacing", cyc + 1, 5);
        check_out("b2b_second");
        tick();

        // Reset during the third RUN cycle aborts with no done pulse
        launch(8'h93, 8'h19, 1'b0);
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort_pre_err", err, 1);
        check("abort_pre_busy", busy, 1);
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        sb.delete();
        check("abort_ready", ready, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 8'h00);
        check("abort_err", err, 0);
        seen = 0;
        repeat (8) begin
            tick();
            if (done === 1'b1) seen++;
        end
        check("abort_no_done", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
